// File: rtl/branch_resolver_pkg.sv
// Shared pipeline constants and FSM encoding for the branch resolver.
package branch_resolver_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    FLUSHING = 1'b1
  } fsm_state_t;

  localparam int unsigned DEFAULT_FLUSH_CYCLES = 2;
  localparam int unsigned INSTR_BYTES          = 4;
  // Wide enough for FLUSH_CYCLES-1 over the legal range 1..7.
  localparam int unsigned FLUSH_CNT_WIDTH      = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for branch statistics; sticks at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc unless already saturated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: detects mispredictions, redirects fetch,
// trains the predictor, flushes younger stages and keeps statistics.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned FLUSH_CYCLES  = DEFAULT_FLUSH_CYCLES,
  parameter int unsigned COUNT_WIDTH   = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     STALL,
  input  logic                     BRANCH_VALID,
  input  logic [ADDRESS_WIDTH-1:0] PC_EXECUTION,
  input  logic                     PREDICTED_TAKEN,
  input  logic [ADDRESS_WIDTH-1:0] PC_PREDICTED_EX,
  input  logic                     BRANCH_TAKEN,
  input  logic [ADDRESS_WIDTH-1:0] BRANCH_TARGET,
  output logic [ADDRESS_WIDTH-1:0] PC_PREDICT_LEARN,
  output logic                     PC_PREDICT_LEARN_SELECT,
  output logic                     LEARN_TAKEN,
  output logic [ADDRESS_WIDTH-1:0] PC_REDIRECT,
  output logic                     PC_REDIRECT_VALID,
  output logic                     FLUSH,
  output logic [COUNT_WIDTH-1:0]   BRANCH_COUNT,
  output logic [COUNT_WIDTH-1:0]   MISPREDICT_COUNT
);

  fsm_state_t                 state, state_next;
  logic [FLUSH_CNT_WIDTH-1:0] flush_cnt, flush_cnt_next;
  logic                       sample;
  logic                       mispredict;
  logic                       learn;
  logic [ADDRESS_WIDTH-1:0]   next_pc;

  // Branch evaluation: sampling qualifier, mispredict test, correct next PC.
  always_comb begin
    sample     = BRANCH_VALID && !STALL && (state == IDLE);
    mispredict = (PREDICTED_TAKEN != BRANCH_TAKEN) ||
                 (PREDICTED_TAKEN && BRANCH_TAKEN && (PC_PREDICTED_EX != BRANCH_TARGET));
    learn      = sample && (mispredict || BRANCH_TAKEN);
    next_pc    = BRANCH_TAKEN ? BRANCH_TARGET
                              : PC_EXECUTION + ADDRESS_WIDTH'(INSTR_BYTES);
  end

  // Next-state and flush down-counter; everything holds while stalled.
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    if (!STALL) begin
      case (state)
        IDLE: begin
          if (sample && mispredict) begin
            state_next     = FLUSHING;
            flush_cnt_next = FLUSH_CNT_WIDTH'(FLUSH_CYCLES - 1);
          end
        end
        FLUSHING: begin
          if (flush_cnt == '0) begin
            state_next = IDLE;
          end else begin
            flush_cnt_next = flush_cnt - FLUSH_CNT_WIDTH'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State register and flush counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  // Registered responses; FLUSH tracks the registered FSM state so it is
  // high for exactly the cycles spent in FLUSHING.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      FLUSH                   <= 1'b0;
      PC_REDIRECT_VALID       <= 1'b0;
      PC_PREDICT_LEARN_SELECT <= 1'b0;
      LEARN_TAKEN             <= 1'b0;
      PC_PREDICT_LEARN        <= '0;
      PC_REDIRECT             <= '0;
    end else begin
      FLUSH                   <= (state_next == FLUSHING);
      PC_REDIRECT_VALID       <= sample && mispredict;
      PC_PREDICT_LEARN_SELECT <= learn;
      if (sample && mispredict) begin
        PC_REDIRECT <= next_pc;
      end
      if (learn) begin
        PC_PREDICT_LEARN <= BRANCH_TARGET;
        LEARN_TAKEN      <= BRANCH_TAKEN;
      end
    end
  end

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_branch_count (
    .clk   (CLK),
    .rst   (RST),
    .inc   (sample),
    .count (BRANCH_COUNT)
  );

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_mispredict_count (
    .clk   (CLK),
    .rst   (RST),
    .inc   (sample && mispredict),
    .count (MISPREDICT_COUNT)
  );

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver.
module tb_branch_resolver;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        valid;
  logic [31:0] pc_ex;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        taken;
  logic [31:0] target;
  logic [31:0] learn_pc;
  logic        learn_sel;
  logic        learn_taken;
  logic [31:0] redirect_pc;
  logic        redirect_valid;
  logic        flush;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  // Narrow-counter, single-flush-cycle instance for saturation checks.
  logic        s_rst;
  logic        s_stall;
  logic        s_valid;
  logic [31:0] s_pc;
  logic        s_pred_taken;
  logic [31:0] s_pred_target;
  logic        s_taken;
  logic [31:0] s_target;
  logic [31:0] s_learn_pc;
  logic        s_learn_sel;
  logic        s_learn_taken;
  logic [31:0] s_redirect_pc;
  logic        s_redirect_valid;
  logic        s_flush;
  logic [3:0]  s_branch_count;
  logic [3:0]  s_mispredict_count;

  int compared = 0;
  int mismatched = 0;

  branch_resolver dut (
    .CLK                     (clk),
    .RST                     (rst),
    .STALL                   (stall),
    .BRANCH_VALID            (valid),
    .PC_EXECUTION            (pc_ex),
    .PREDICTED_TAKEN         (pred_taken),
    .PC_PREDICTED_EX         (pred_target),
    .BRANCH_TAKEN            (taken),
    .BRANCH_TARGET           (target),
    .PC_PREDICT_LEARN        (learn_pc),
    .PC_PREDICT_LEARN_SELECT (learn_sel),
    .LEARN_TAKEN             (learn_taken),
    .PC_REDIRECT             (redirect_pc),
    .PC_REDIRECT_VALID       (redirect_valid),
    .FLUSH                   (flush),
    .BRANCH_COUNT            (branch_count),
    .MISPREDICT_COUNT        (mispredict_count)
  );

  branch_resolver #(
    .ADDRESS_WIDTH (32),
    .FLUSH_CYCLES  (1),
    .COUNT_WIDTH   (4)
  ) dut_sat (
    .CLK                     (clk),
    .RST                     (s_rst),
    .STALL                   (s_stall),
    .BRANCH_VALID            (s_valid),
    .PC_EXECUTION            (s_pc),
    .PREDICTED_TAKEN         (s_pred_taken),
    .PC_PREDICTED_EX         (s_pred_target),
    .BRANCH_TAKEN            (s_taken),
    .BRANCH_TARGET           (s_target),
    .PC_PREDICT_LEARN        (s_learn_pc),
    .PC_PREDICT_LEARN_SELECT (s_learn_sel),
    .LEARN_TAKEN             (s_learn_taken),
    .PC_REDIRECT             (s_redirect_pc),
    .PC_REDIRECT_VALID       (s_redirect_valid),
    .FLUSH                   (s_flush),
    .BRANCH_COUNT            (s_branch_count),
    .MISPREDICT_COUNT        (s_mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic pt,
                       input logic [31:0] ptgt, input logic t, input logic [31:0] tgt);
    valid       = v;
    pc_ex       = pc;
    pred_taken  = pt;
    pred_target = ptgt;
    taken       = t;
    target      = tgt;
  endtask

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
    s_rst         = 1'b1;
    s_stall       = 1'b0;
    s_valid       = 1'b1;
    s_pc          = 32'h0000_1000;
    s_pred_taken  = 1'b0;
    s_pred_target = 32'h0;
    s_taken       = 1'b1;
    s_target      = 32'h0000_2000;

    // Reset state
    @(negedge clk);
    check("rst_flush", flush, 0);
    check("rst_redirect_valid", redirect_valid, 0);
    check("rst_learn_sel", learn_sel, 0);
    check("rst_learn_taken", learn_taken, 0);
    check("rst_learn_pc", learn_pc, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_bcount", branch_count, 0);
    check("rst_mcount", mispredict_count, 0);
    rst = 1'b0;

    // Predicted not-taken, actually taken to 0x100 at PC 0x40
    drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
    tick();
    check("t1_redirect_pc", redirect_pc, 32'h100);
    check("t1_redirect_valid", redirect_valid, 1);
    check("t1_learn_sel", learn_sel, 1);
    check("t1_learn_pc", learn_pc, 32'h100);
    check("t1_learn_taken", learn_taken, 1);
    check("t1_flush_c1", flush, 1);
    check("t1_mcount", mispredict_count, 1);
    check("t1_bcount", branch_count, 1);
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
    tick();
    check("t1_flush_c2", flush, 1);
    check("t1_redirect_valid_c2", redirect_valid, 0);
    check("t1_learn_sel_c2", learn_sel, 0);
    check("t1_redirect_hold", redirect_pc, 32'h100);
    tick();
    check("t1_flush_end", flush, 0);

    // Correctly predicted taken to 0x200: learn only
    drive(1'b1, 32'h80, 1'b1, 32'h200, 1'b1, 32'h200);
    tick();
    check("t2_learn_sel", learn_sel, 1);
    check("t2_learn_pc", learn_pc, 32'h200);
    check("t2_learn_taken", learn_taken, 1);
    check("t2_redirect_valid", redirect_valid, 0);
    check("t2_redirect_hold", redirect_pc, 32'h100);
    check("t2_flush", flush, 0);
    check("t2_bcount", branch_count, 2);
    check("t2_mcount", mispredict_count, 1);

    // Correctly predicted not-taken: counted, no strobes
    drive(1'b1, 32'h84, 1'b0, 32'h0, 1'b0, 32'h999);
    tick();
    check("t2b_learn_sel", learn_sel, 0);
    check("t2b_redirect_valid", redirect_valid, 0);
    check("t2b_learn_hold", learn_pc, 32'h200);
    check("t2b_bcount", branch_count, 3);
    check("t2b_flush", flush, 0);

    // Predicted taken, actually not-taken at 0xFFFF_FFFC: next PC wraps to 0
    drive(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h300, 1'b0, 32'h1234);
    tick();
    check("t3_redirect_pc", redirect_pc, 32'h0);
    check("t3_redirect_valid", redirect_valid, 1);
    check("t3_learn_sel", learn_sel, 1);
    check("t3_learn_taken", learn_taken, 0);
    check("t3_learn_pc", learn_pc, 32'h1234);
    check("t3_flush", flush, 1);
    check("t3_bcount", branch_count, 4);
    check("t3_mcount", mispredict_count, 2);

    // Wrong-path branches during both flush cycles are ignored
    drive(1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 32'h600);
    tick();
    check("t4_ign1_redirect_valid", redirect_valid, 0);
    check("t4_ign1_learn_sel", learn_sel, 0);
    check("t4_ign1_bcount", branch_count, 4);
    check("t4_ign1_flush", flush, 1);
    tick();
    check("t4_ign2_redirect_valid", redirect_valid, 0);
    check("t4_ign2_learn_sel", learn_sel, 0);
    check("t4_ign2_bcount", branch_count, 4);
    check("t4_ign2_mcount", mispredict_count, 2);
    check("t4_ign2_flush", flush, 0);
    tick();
    check("t4_after_redirect_valid", redirect_valid, 1);
    check("t4_after_redirect_pc", redirect_pc, 32'h600);
    check("t4_after_bcount", branch_count, 5);
    check("t4_after_mcount", mispredict_count, 3);
    check("t4_after_flush", flush, 1);

    // Stall three cycles mid-flush: FLUSH held, counters frozen
    stall = 1'b1;
    drive(1'b1, 32'h700, 1'b0, 32'h0, 1'b1, 32'h800);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_stall_flush", flush, 1);
      check("t5_stall_strobe", {redirect_valid, learn_sel}, 2'b00);
      check("t5_stall_bcount", branch_count, 5);
    end
    stall = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
    tick();
    check("t5_flush_c2", flush, 1);
    tick();
    check("t5_flush_end", flush, 0);

    // Both taken, target mismatch is a mispredict
    drive(1'b1, 32'h700, 1'b1, 32'h800, 1'b1, 32'h900);
    tick();
    check("t6_redirect_valid", redirect_valid, 1);
    check("t6_redirect_pc", redirect_pc, 32'h900);
    check("t6_learn_pc", learn_pc, 32'h900);
    check("t6_bcount", branch_count, 6);
    check("t6_mcount", mispredict_count, 4);
    check("t6_flush", flush, 1);
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0);

    // Asynchronous reset mid-flush, checked before any clock edge
    #2;
    rst = 1'b1;
    #1;
    check("t7_rst_flush", flush, 0);
    check("t7_rst_bcount", branch_count, 0);
    check("t7_rst_mcount", mispredict_count, 0);
    check("t7_rst_redirect_pc", redirect_pc, 0);
    check("t7_rst_learn_pc", learn_pc, 0);
    @(negedge clk);
    rst = 1'b0;

    // First edge after reset release samples
    drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
    tick();
    check("t8_redirect_valid", redirect_valid, 1);
    check("t8_bcount", branch_count, 1);
    check("t8_flush", flush, 1);
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
    tick();
    tick();
    check("t8_flush_end", flush, 0);

    // Stalled branch in IDLE is not sampled
    stall = 1'b1;
    drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h140);
    tick();
    check("t9_stall_strobe", {redirect_valid, learn_sel}, 2'b00);
    check("t9_stall_bcount", branch_count, 1);
    check("t9_stall_flush", flush, 0);
    stall = 1'b0;
    tick();
    check("t9_redirect_valid", redirect_valid, 1);
    check("t9_redirect_pc", redirect_pc, 32'h140);
    check("t9_bcount", branch_count, 2);
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0);

    // Saturation on the 4-bit, one-flush-cycle instance
    @(negedge clk);
    s_rst = 1'b0;
    tick();
    check("s_mcount_1", s_mispredict_count, 1);
    check("s_flush_1", s_flush, 1);
    tick();
    check("s_flush_end", s_flush, 0);
    tick();
    check("s_mcount_2", s_mispredict_count, 2);
    repeat (40) tick();
    check("s_mcount_sat", s_mispredict_count, 4'hF);
    check("s_bcount_sat", s_branch_count, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
